// File: rtl/avalon_pulse_pio.sv
// Avalon-MM output PIO with DATA/SET/CLEAR access and a self-timed pulse engine.
// Selected output bits invert for PULSE_CYCLES clocks and then restore. When a
// pulse completes, a done flag is set and can raise a level interrupt.
module avalon_pulse_pio #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned RESET_VALUE  = 0,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned     CW         = $clog2(PULSE_CYCLES + 1);
    localparam logic [WIDTH-1:0] RST_DATA  = WIDTH'(RESET_VALUE);
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(PULSE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_IRQEN  = 3'd5;

    typedef enum logic {
        IDLE    = 1'b0,
        PULSING = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] pulse_mask_q;
    logic [CW-1:0]    count_q;
    logic             done_q;
    logic             overrun_q;
    logic             irq_en_q;

    logic             wr_c;
    logic [WIDTH-1:0] wd_c;
    logic             busy_c;
    logic [31:0]      unused_wd_c;

    assign wr_c        = chipselect & ~write_n;
    assign wd_c        = writedata[WIDTH-1:0];
    assign busy_c      = (state_q == PULSING);
    // Bits above WIDTH carry no meaning for this block.
    assign unused_wd_c = writedata;

    // Next value of the base register from DATA/SET/CLEAR writes.
    always_comb begin
        data_d = data_q;
        if (wr_c) begin
            case (address)
                ADDR_DATA:  data_d = wd_c;
                ADDR_SET:   data_d = data_q | wd_c;
                ADDR_CLEAR: data_d = data_q & ~wd_c;
                default:    data_d = data_q;
            endcase
        end
    end

    // Base register; updates immediately even while a pulse is running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RST_DATA;
        end else begin
            data_q <= data_d;
        end
    end

    // Pulse FSM with status flags; a completion or overrun event beats a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pulse_mask_q <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            irq_en_q     <= 1'b0;
        end else begin
            if (wr_c && address == ADDR_STATUS) begin
                if (writedata[1]) done_q    <= 1'b0;
                if (writedata[2]) overrun_q <= 1'b0;
            end
            if (wr_c && address == ADDR_IRQEN) begin
                irq_en_q <= writedata[0];
            end
            case (state_q)
                IDLE: begin
                    if (wr_c && address == ADDR_PULSE && wd_c != '0) begin
                        state_q      <= PULSING;
                        pulse_mask_q <= wd_c;
                        count_q      <= CNT_LOAD;
                    end
                end
                PULSING: begin
                    if (wr_c && address == ADDR_PULSE) begin
                        overrun_q <= 1'b1;
                    end
                    if (count_q == '0) begin
                        state_q      <= IDLE;
                        pulse_mask_q <= '0;
                        done_q       <= 1'b1;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_port = data_q ^ (busy_c ? pulse_mask_q : '0);
    assign irq      = done_q & irq_en_q;

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_PULSE:  readdata = 32'(pulse_mask_q);
            ADDR_STATUS: readdata = {29'd0, overrun_q, done_q, busy_c};
            ADDR_IRQEN:  readdata = {31'd0, irq_en_q};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pulse_pio.sv
// Bench for avalon_pulse_pio: directed scenarios plus random bus traffic,
// compared every cycle against a time-based reference model.
module tb_avalon_pulse_pio;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned RESET_VALUE  = 8'h01;
    localparam int unsigned PULSE_CYCLES = 16;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    int n_cmp;
    int n_err;

    // Reference model: a pulse is described by the edge at which it ends.
    int               m_edge;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    bit               m_active;
    int               m_end;
    bit               m_done;
    bit               m_over;
    bit               m_irqen;

    avalon_pulse_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data   = WIDTH'(RESET_VALUE);
        m_mask   = '0;
        m_active = 1'b0;
        m_end    = 0;
        m_done   = 1'b0;
        m_over   = 1'b0;
        m_irqen  = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return m_active ? 32'(m_mask) : 32'd0;
            3'd4:    return {29'd0, m_over, m_done, m_active};
            3'd5:    return {31'd0, m_irqen};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input logic [2:0] a, input bit wr, input logic [31:0] wd);
        bit               was_busy;
        bit               over_evt;
        logic [WIDTH-1:0] v;
        m_edge++;
        was_busy = m_active;
        over_evt = 1'b0;
        v        = wd[WIDTH-1:0];
        if (wr) begin
            case (a)
                3'd0: m_data = v;
                3'd1: m_data = m_data | v;
                3'd2: m_data = m_data & ~v;
                3'd3: begin
                    if (was_busy) over_evt = 1'b1;
                    else if (v != 0) begin
                        m_active = 1'b1;
                        m_mask   = v;
                        m_end    = m_edge + int'(PULSE_CYCLES);
                    end
                end
                3'd4: begin
                    if (wd[1]) m_done = 1'b0;
                    if (wd[2]) m_over = 1'b0;
                end
                3'd5: m_irqen = wd[0];
                default: ;
            endcase
        end
        if (over_evt) m_over = 1'b1;
        if (was_busy && m_edge == m_end) begin
            m_active = 1'b0;
            m_mask   = '0;
            m_done   = 1'b1;
        end
    endfunction

    // One bus cycle: check the read mux, clock, then check outputs.
    task automatic bus(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        #1;
        chk("readdata", readdata, model_read(a));
        @(posedge clk);
        model_edge(a, cs & ~wn, wd);
        #1;
        chk("out_port", 32'(out_port), 32'(m_data ^ (m_active ? m_mask : '0)));
        chk("irq", 32'(irq), 32'(m_done & m_irqen));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        bus(a, 1'b1, 1'b0, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(3'd0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic rd_exp(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        chk(tag, readdata, exp);
        bus(a, 1'b1, 1'b1, 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        m_edge     = 0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        reset_n    = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_out_port", 32'(out_port), 32'h01);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_exp("rst_data", 3'd0, 32'h01);
        rd_exp("rst_status", 3'd4, 32'h0);

        // DATA/SET/CLEAR
        wr(3'd0, 32'hFFFF_FFA5);
        chk("data_a5", 32'(out_port), 32'hA5);
        wr(3'd1, 32'h0A);
        chk("set_0a", 32'(out_port), 32'hAF);
        wr(3'd2, 32'h81);
        chk("clear_81", 32'(out_port), 32'h2E);
        rd_exp("set_reads0", 3'd1, 32'h0);
        rd_exp("clear_reads0", 3'd2, 32'h0);

        // Basic pulse with interrupt
        wr(3'd0, 32'h00);
        wr(3'd5, 32'h1);
        wr(3'd3, 32'h03);
        chk("pulse_first", 32'(out_port), 32'h03);
        rd_exp("busy", 3'd4, 32'h1);
        idle(14);
        chk("pulse_last", 32'(out_port), 32'h03);
        idle(1);
        chk("pulse_restored", 32'(out_port), 32'h00);
        chk("irq_after_pulse", 32'(irq), 32'h1);
        wr(3'd4, 32'h2);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Overrun and SET during a pulse
        wr(3'd3, 32'h03);
        wr(3'd3, 32'hF0);
        rd_exp("pulse_mask_kept", 3'd3, 32'h03);
        wr(3'd1, 32'h10);
        chk("set_mid_pulse", 32'(out_port), 32'h13);
        idle(20);
        chk("restore_updated", 32'(out_port), 32'h10);
        rd_exp("done_overrun", 3'd4, 32'h6);
        wr(3'd4, 32'h6);

        // Zero-mask pulse and done set-wins
        wr(3'd3, 32'h100);
        rd_exp("zero_mask_status", 3'd4, 32'h0);
        wr(3'd3, 32'h01);
        idle(15);
        wr(3'd4, 32'h2);
        rd_exp("done_set_wins", 3'd4, 32'h2);
        wr(3'd4, 32'h2);

        // Reset in the middle of a pulse
        wr(3'd3, 32'h0C);
        idle(4);
        address   = 3'd4;
        chipselect = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_out_port", 32'(out_port), 32'h01);
        chk("midrst_status", readdata, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(20);
        rd_exp("midrst_no_done", 3'd4, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3 && $urandom_range(0, 3) == 0) d = d & 32'hFFFF_FF00;
            bus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
